matrix_ula: RTL
===============

// Module: matrix_ula
// PURPOSE
// Parametrised successor of the single-op matrix ALU in the coprocessor datapath.
// Operates on two NxN matrices of W-bit signed elements and an optional scalar:
// add, sub, matrix multiply, scalar multiply, transpose and negate. Matrix
// multiply is iterative, producing one result row per cycle. Sits between the
// operand register bank and the writeback stage; uses the same start/done level
// handshake as the existing ALU.
// PARAMETERS
// N  5  matrix dimension (rows = cols), N >= 2
// W  8  element width in bits, two's complement signed
// PORTS
// clk                input   1      rising-edge clock
// reset              input   1      asynchronous, active-high reset
// start              input   1      level request; op accepted on rising edge while IDLE
// opcode             input   4      operation select (table below)
// data_escalar       input   W      signed scalar for opcode 4
// matrizA            input   N*N*W  operand A; element (r,c) at [(r*N+c)*W +: W]
// matrizB            input   N*N*W  operand B; same packing
// matriz_resultante  output  N*N*W  result; valid only while done=1
// done               output  1      operation complete; held until start=0
// overflow           output  1      signed overflow in any element of the last op
// error              output  1      last opcode was invalid
// BEHAVIOUR
// - Reset (async): state=IDLE, row counter=0, all outputs=0 (result all-zero).
// - Opcodes: 0 NOP, 1 A+B, 2 A-B, 3 A*B (matrix product), 4 scalar*A,
//   5 transpose(A), 6 -A; 7..15 invalid.
// - FSM: IDLE -> EXEC | MUL -> DONE -> IDLE.
//   IDLE: done=0. If start=1 at an edge, latch A, B, opcode and scalar, clear
//     overflow and error, then go to MUL (opcode 3) or EXEC (all others).
//     Input changes after latching have no effect.
//   EXEC: at the next edge, write the full result, set done=1, go to DONE.
//     NOP and invalid opcodes leave the result unchanged.
//     An invalid opcode also sets error=1.
//   MUL: row counter r = 0..N-1. Each edge writes result row r, where
//     C[r][c] = sum_k A[r][k]*B[k][c]. On the edge writing row N-1: set done=1,
//     reset r to 0, go to DONE.
//   DONE: done=1 and the result is stable. When start=0 at an edge: done=0,
//     go to IDLE. While start stays high, no new op starts.
// - Latency, counted from the edge that samples start=1:
//   done rises after 2 edges for non-multiply ops, after N+1 edges for opcode 3.
//   Minimum restart: start low for 1 cycle after done.
// - Arithmetic: results are truncated to W bits (mod 2^W).
//   overflow=1 if any element's exact signed result falls outside
//   [-2^(W-1), 2^(W-1)-1].
//   Multiply accumulates at 2W+clog2(N) bits before the range check.
//   Negating -2^(W-1) overflows.
//   overflow and error are sticky within an op and update with done.
// - The result register may hold partial rows during MUL. Consumers must
//   sample it only while done=1.
// - Reset asserted in any state aborts the op immediately: IDLE, outputs zeroed.
//   No done pulse follows.
// - If opcode changes while start is held in DONE, it is ignored until the
//   next IDLE acceptance.
// TESTING (N=5, W=8)
// 1. A all 10, B all 20, op 1 -> result all 30, done 2 edges after start,
//    overflow=0.
// 2. A[0][0]=127, B[0][0]=1, rest 0, op 1 -> elem(0,0)=0x80, overflow=1;
//    op 2 with A=0, B=1 -> all 0xFF, overflow=0.
// 3. A = identity, B[r][c]=r*5+c, op 3 -> result = B; done exactly 6 edges
//    after start; done=0 on edges 1..5.
// 4. A[r][c]=r*5+c, op 5 -> result(r,c)=c*5+r; op 4 with scalar=-1 on the same
//    A -> result = -A, overflow=0.
// 5. start held high 10 cycles after done -> done stays 1, result unchanged,
//    no re-execution. Drop start -> done=0 next edge. Invalid op 0xF ->
//    error=1, result unchanged.
// 6. Assert reset on the 3rd MUL edge -> done=0, result=0, IDLE. A new op 1
//    then completes normally.

Source files
------------

// File: rtl/matrix_ula.sv
// Matrix ALU for NxN signed W-bit operands: add, sub, product, scalar multiply,
// transpose and negate, driven by a start/done level handshake.
module matrix_ula #(
    parameter int N = 5,
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [W-1:0]     data_escalar,
    input  logic [N*N*W-1:0] matrizA,
    input  logic [N*N*W-1:0] matrizB,
    output logic [N*N*W-1:0] matriz_resultante,
    output logic             done,
    output logic             overflow,
    output logic             error
);
    localparam int RW = $clog2(N);
    localparam int AW = 2*W + $clog2(N);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_e;
    typedef enum logic [3:0] {
        OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_MUL = 4'd3,
        OP_SCL = 4'd4, OP_TRN = 4'd5, OP_NEG = 4'd6
    } op_e;

    state_e             state;
    logic [RW-1:0]      r_q;
    logic [N*N*W-1:0]   a_q, b_q;
    logic [3:0]         op_q;
    logic [W-1:0]       sc_q;
    logic               ovf_acc;

    logic [N*N*W-1:0]   exec_res, row_res;
    logic               exec_ovf, exec_err, row_ovf;
    logic signed [W-1:0]   ea, eb, ma, mb;
    logic signed [W:0]     wide;
    logic signed [2*W-1:0] prod;
    logic signed [AW-1:0]  acc;
    logic [31:0]           row_i;

    assign row_i = 32'(r_q);

    // Whole-matrix element-wise ops; NOP and invalid codes keep the old result.
    always_comb begin
        exec_res = matriz_resultante;
        exec_ovf = 1'b0;
        exec_err = 1'b0;
        ea = '0;
        eb = '0;
        wide = '0;
        prod = '0;
        for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned c = 0; c < N; c++) begin
                ea = a_q[(r*N+c)*W +: W];
                eb = b_q[(r*N+c)*W +: W];
                wide = '0;
                prod = '0;
                case (op_q)
                    OP_ADD, OP_SUB, OP_NEG: begin
                        if (op_q == OP_ADD)      wide = {ea[W-1], ea} + {eb[W-1], eb};
                        else if (op_q == OP_SUB) wide = {ea[W-1], ea} - {eb[W-1], eb};
                        else                     wide = -{ea[W-1], ea};
                        exec_res[(r*N+c)*W +: W] = wide[W-1:0];
                        exec_ovf = exec_ovf | (wide[W] ^ wide[W-1]);
                    end
                    OP_SCL: begin
                        prod = (2*W)'(ea) * (2*W)'($signed(sc_q));
                        exec_res[(r*N+c)*W +: W] = prod[W-1:0];
                        exec_ovf = exec_ovf | ~(&prod[2*W-1:W-1] | ~|prod[2*W-1:W-1]);
                    end
                    OP_TRN: exec_res[(r*N+c)*W +: W] = a_q[(c*N+r)*W +: W];
                    OP_NOP, OP_MUL: ;
                    default: exec_err = 1'b1;
                endcase
            end
        end
    end

    // One product row per cycle, full-width accumulation before the range check.
    always_comb begin
        row_res = matriz_resultante;
        row_ovf = 1'b0;
        acc = '0;
        ma = '0;
        mb = '0;
        for (int unsigned c = 0; c < N; c++) begin
            acc = '0;
            for (int unsigned k = 0; k < N; k++) begin
                ma = a_q[(row_i*N+k)*W +: W];
                mb = b_q[(k*N+c)*W +: W];
                acc = acc + AW'(ma) * AW'(mb);
            end
            row_res[(row_i*N+c)*W +: W] = acc[W-1:0];
            row_ovf = row_ovf | ~(&acc[AW-1:W-1] | ~|acc[AW-1:W-1]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            r_q               <= '0;
            a_q               <= '0;
            b_q               <= '0;
            op_q              <= '0;
            sc_q              <= '0;
            ovf_acc           <= 1'b0;
            matriz_resultante <= '0;
            done              <= 1'b0;
            overflow          <= 1'b0;
            error             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q      <= matrizA;
                        b_q      <= matrizB;
                        op_q     <= opcode;
                        sc_q     <= data_escalar;
                        overflow <= 1'b0;
                        error    <= 1'b0;
                        ovf_acc  <= 1'b0;
                        r_q      <= '0;
                        state    <= (opcode == OP_MUL) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    matriz_resultante <= exec_res;
                    overflow          <= exec_ovf;
                    error             <= exec_err;
                    done              <= 1'b1;
                    state             <= DONE;
                end
                MUL: begin
                    matriz_resultante <= row_res;
                    ovf_acc           <= ovf_acc | row_ovf;
                    if (r_q == RW'(N-1)) begin
                        overflow <= ovf_acc | row_ovf;
                        done     <= 1'b1;
                        r_q      <= '0;
                        state    <= DONE;
                    end else begin
                        r_q <= r_q + RW'(1);
                    end
                end
                DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
